rr_arb64_4: RTL and testbench
=============================

RR_ARB64_4 -- requirements
Module: rr_arb64_4

Interface
REQ-001 Parameter: DATA_W, 64, data width of each channel and of the output; the bench SHALL exercise 64.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 y0, y1, y2, y3  input  DATA_W  channel 0..3 data.
REQ-005 in_valid  input  4  bit i set: channel i offers a beat on yi.
REQ-006 in_ready  output  4  bit i set: channel i beat accepted this cycle.
REQ-007 z  output  DATA_W  registered data of the granted channel.
REQ-008 z_valid  output  1  z holds a beat.
REQ-009 z_ready  input  1  downstream accepts z this cycle.
REQ-010 x  output  2  index of the channel z came from; drives the select of the downstream 64-bit 4:1 selector.

Function
REQ-011 Load condition: load = !z_valid || z_ready.
REQ-012 Grant: when load and in_valid != 0, grant g = first set bit of in_valid searching ptr, ptr+1, ... mod 4.
REQ-013 in_ready SHALL be combinational, one-hot at bit g when load and a grant exists, otherwise 4'b0000.
REQ-014 On grant: z <= yg, x <= g, z_valid <= 1, ptr <= (g+1) mod 4.
REQ-015 When load and in_valid == 0: z_valid <= 0; z, x and ptr hold.
REQ-016 When z_valid && !z_ready: z, x, z_valid and ptr SHALL hold, and in_ready == 0.
REQ-017 Latency 1 cycle from accepted input beat to z_valid; sustained throughput 1 beat/cycle with z_ready held high.
REQ-018 A channel not granted SHALL NOT be consumed; its data and valid remain the upstream's responsibility.
REQ-019 Fairness: with all four channels continuously valid, grants SHALL rotate 0,1,2,3,0,...
REQ-020 ptr wraps 3 -> 0; a 2-bit counter with natural overflow is acceptable.

Reset
REQ-021 While rst_n == 0: z = 0, z_valid = 0, x = 0, ptr = 0, in_ready = 0, independent of clk.
REQ-022 Reset mid-transfer SHALL discard any held beat.
REQ-023 After deassertion, the first grant SHALL search from channel 0.

Configuration
REQ-024 Macro RR_ARB_LOCK_EN.
- Defined: adds input in_last [3:0]. After channel g is granted a beat with in_last[g] == 0, the arbiter stays locked to g and ignores other channels until a beat from g with in_last[g] == 1 is accepted. ptr advances only on that last beat.
- Not defined: the in_last port is absent and arbitration is per beat as in REQ-012..REQ-014.
REQ-025 Under lock with in_valid[g] == 0, in_ready SHALL be 0 and z_valid falls per REQ-015.

Verification
REQ-026 Reset with in_valid = 4'b1111 and z_ready = 1 -> in_ready = 0 and z_valid = 0 during reset; after release, x sequence 0,1,2,3,0 on consecutive cycles.
REQ-027 in_valid = 4'b0100, y2 = 64'hDEAD_BEEF_0123_4567, z_ready = 1 -> in_ready = 4'b0100 in cycle N; z = that value, x = 2, z_valid = 1 in cycle N+1.
REQ-028 z_valid = 1, z_ready = 0 held 3 cycles with in_valid = 4'b1111 -> z and x stable, in_ready = 0 throughout; on z_ready = 1, the next grant is ptr's channel.
REQ-029 Last grant = 3, then in_valid = 4'b1001 -> next x = 0, not 3 (wrap-around).
REQ-030 Assert rst_n = 0 asynchronously between clock edges while z_valid = 1 -> z_valid = 0 and x = 0 immediately, without waiting for a clock edge.
REQ-031 With RR_ARB_LOCK_EN: channel 1 sends 3 beats with in_last = 0,0,1 while in_valid = 4'b1111 -> x = 1,1,1 then 2.

Source files
------------

// File: rtl/rr_arb64_4.sv
// Four-channel round-robin arbiter with a registered output stage and a 2-bit source index.
// Optional build macro RR_ARB_LOCK_EN adds in_last and keeps a multi-beat packet on one channel.
module rr_arb64_4 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] y0,
    input  logic [DATA_W-1:0] y1,
    input  logic [DATA_W-1:0] y2,
    input  logic [DATA_W-1:0] y3,
    input  logic [3:0]        in_valid,
`ifdef RR_ARB_LOCK_EN
    input  logic [3:0]        in_last,
`endif
    output logic [3:0]        in_ready,
    output logic [DATA_W-1:0] z,
    output logic              z_valid,
    input  logic              z_ready,
    output logic [1:0]        x
);

    logic [1:0]        ptr;
    logic              load;
    logic [3:0]        req;
    logic              gnt_vld;
    logic [1:0]        gnt;
    logic [1:0]        cand;
    logic              fire;
    logic              ptr_adv;
    logic [DATA_W-1:0] y_sel;

    assign load = !z_valid || z_ready;

`ifdef RR_ARB_LOCK_EN
    // state   | meaning
    // ST_FREE | arbitrate per beat starting at ptr
    // ST_LOCK | mid-packet; only lock_ch may be granted
    typedef enum logic {
        ST_FREE = 1'b0,
        ST_LOCK = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;
    logic [1:0]  lock_ch_q, lock_ch_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FREE;
            lock_ch_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        if (fire) begin
            if (in_last[gnt]) begin
                state_d = ST_FREE;
            end else begin
                state_d   = ST_LOCK;
                lock_ch_d = gnt;
            end
        end
    end

    assign req     = (state_q == ST_LOCK) ? (in_valid & (4'b0001 << lock_ch_q)) : in_valid;
    assign ptr_adv = in_last[gnt];
`else
    assign req     = in_valid;
    assign ptr_adv = 1'b1;
`endif

    // Descending scan so the candidate closest to ptr is the last one written and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr;
        cand    = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held, regardless of clk.
    assign fire     = rst_n && load && gnt_vld;
    assign in_ready = fire ? (4'b0001 << gnt) : 4'b0000;

    always_comb begin
        y_sel = y0;
        case (gnt)
            2'd0: y_sel = y0;
            2'd1: y_sel = y1;
            2'd2: y_sel = y2;
            2'd3: y_sel = y3;
            default: y_sel = y0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z       <= '0;
            x       <= 2'd0;
            z_valid <= 1'b0;
            ptr     <= 2'd0;
        end else if (fire) begin
            z       <= y_sel;
            x       <= gnt;
            z_valid <= 1'b1;
            if (ptr_adv) begin
                ptr <= gnt + 2'd1;
            end
        end else if (load) begin
            z_valid <= 1'b0;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready));

    a_stall_no_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (z_valid && !z_ready) |-> (in_ready == 4'b0000));

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (z_valid && !z_ready) |=> (z_valid && $stable(z) && $stable(x)));

endmodule

// File: tb/tb_rr_arb64_4.sv
// Bench for rr_arb64_4: directed vector table, a behavioural round-robin model checked under
// random traffic, async reset corner cases, and the packet-lock sequence when RR_ARB_LOCK_EN is set.
module tb_rr_arb64_4;

    logic        clk;
    logic        rst_n;
    logic [63:0] yv [4];
    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [63:0] z;
    logic        zv;
    logic        zr;
    logic [1:0]  x;
`ifdef RR_ARB_LOCK_EN
    logic [3:0]  lk;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    rr_arb64_4 #(.DATA_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .y0       (yv[0]),
        .y1       (yv[1]),
        .y2       (yv[2]),
        .y3       (yv[3]),
        .in_valid (iv),
`ifdef RR_ARB_LOCK_EN
        .in_last  (lk),
`endif
        .in_ready (ir),
        .z        (z),
        .z_valid  (zv),
        .z_ready  (zr),
        .x        (x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the arbitration rules stated directly on integers.
    int          m_ptr;
    int          m_x;
    bit          m_zv;
    logic [63:0] m_z;
    bit          m_lock;
    int          m_lch;

    task automatic model_reset();
        m_ptr  = 0;
        m_x    = 0;
        m_zv   = 0;
        m_z    = '0;
        m_lock = 0;
        m_lch  = 0;
    endtask

    function automatic int model_grant();
        if (m_zv && !zr) return -1;
        if (m_lock) return iv[m_lch] ? m_lch : -1;
        for (int k = 0; k < 4; k++) begin
            if (iv[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (g >= 0) begin
            m_z  = yv[g];
            m_x  = g;
            m_zv = 1;
`ifdef RR_ARB_LOCK_EN
            if (lk[g]) begin
                m_lock = 0;
                m_ptr  = (g + 1) % 4;
            end else begin
                m_lock = 1;
                m_lch  = g;
            end
`else
            m_ptr = (g + 1) % 4;
`endif
        end else if (!m_zv || zr) begin
            m_zv = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are set just after a rising edge; in_ready is checked at the falling edge,
    // registered outputs 1 time unit after the next rising edge.
    task automatic run_cycle(input bit use_tab, input logic [3:0] t_ir,
                             input logic [1:0] t_x, input logic t_zv);
        int g;
        logic [3:0] m_ir;
        @(negedge clk);
        g    = model_grant();
        m_ir = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("model_in_ready", {60'd0, ir}, {60'd0, m_ir});
        if (use_tab) chk("tab_in_ready", {60'd0, ir}, {60'd0, t_ir});
        @(posedge clk);
        model_update(g);
        #1;
        chk("model_z_valid", {63'd0, zv}, {63'd0, m_zv});
        chk("model_x", {62'd0, x}, 64'(m_x));
        chk("model_z", z, m_z);
        if (use_tab) begin
            chk("tab_z_valid", {63'd0, zv}, {63'd0, t_zv});
            chk("tab_x", {62'd0, x}, {62'd0, t_x});
            chk("tab_z", z, yv[t_x]);
        end
    endtask

    typedef struct {
        logic [3:0] iv;
        logic       zr;
        logic [3:0] ir;
        logic [1:0] x;
        logic       zv;
    } vec_t;

    vec_t tab [14];

    initial begin
        tab[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        tab[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tab[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tab[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tab[4]  = '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1};
        tab[5]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
        tab[6]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        tab[7]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tab[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1};
        tab[9]  = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1};
        tab[10] = '{4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1};
        tab[11] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tab[12] = '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1};
        tab[13] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1};

        rst_n = 1'b0;
        iv    = 4'b1111;
        zr    = 1'b1;
        yv[0] = 64'h0000_1111_2222_0000;
        yv[1] = 64'h0101_3333_4444_0101;
        yv[2] = 64'hDEAD_BEEF_0123_4567;
        yv[3] = 64'h0303_5555_6666_0303;
`ifdef RR_ARB_LOCK_EN
        lk    = 4'b1111;
`endif
        model_reset();

        #2;
        chk("rst_in_ready", {60'd0, ir}, 64'd0);
        chk("rst_z_valid", {63'd0, zv}, 64'd0);
        chk("rst_x", {62'd0, x}, 64'd0);
        chk("rst_z", z, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clk_in_ready", {60'd0, ir}, 64'd0);
        chk("rst_clk_z_valid", {63'd0, zv}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            iv = tab[i].iv;
            zr = tab[i].zr;
            run_cycle(1'b1, tab[i].ir, tab[i].x, tab[i].zv);
        end

        for (int i = 0; i < 400; i++) begin
            iv    = 4'($urandom_range(0, 15));
            zr    = ($urandom_range(0, 3) != 0);
            yv[0] = {$urandom, $urandom};
            yv[1] = {$urandom, $urandom};
            yv[2] = {$urandom, $urandom};
            yv[3] = {$urandom, $urandom};
`ifdef RR_ARB_LOCK_EN
            lk    = 4'($urandom_range(0, 15));
`endif
            run_cycle(1'b0, 4'b0000, 2'd0, 1'b0);
        end

        // Drain any lock, then leave ptr at 2 with a beat held before the async reset.
        iv = 4'b1111;
        zr = 1'b1;
`ifdef RR_ARB_LOCK_EN
        lk = 4'b1111;
`endif
        run_cycle(1'b0, 4'b0000, 2'd0, 1'b0);
        iv = 4'b0010;
        run_cycle(1'b0, 4'b0000, 2'd0, 1'b0);
        chk("pre_rst_z_valid", {63'd0, zv}, 64'd1);
        iv = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_z_valid", {63'd0, zv}, 64'd0);
        chk("async_x", {62'd0, x}, 64'd0);
        chk("async_z", z, 64'd0);
        chk("async_in_ready", {60'd0, ir}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_cycle(1'b1, 4'b0001, 2'd0, 1'b1);

`ifdef RR_ARB_LOCK_EN
        lk = 4'b1101;
        run_cycle(1'b1, 4'b0010, 2'd1, 1'b1);
        iv = 4'b1101;
        run_cycle(1'b1, 4'b0000, 2'd1, 1'b0);
        iv = 4'b1111;
        run_cycle(1'b1, 4'b0010, 2'd1, 1'b1);
        lk = 4'b1111;
        run_cycle(1'b1, 4'b0010, 2'd1, 1'b1);
        run_cycle(1'b1, 4'b0100, 2'd2, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
